mux4_rr_sequencer: RTL and testbench

Round-robin select sequencer that drives the 2-bit `sel` of the 4:1 mux stage directly downstream. It rotates among requesting channels and holds each grant for a programmable dwell time. It publishes a one-hot grant, a valid flag and a wrap pulse for downstream framing. All outputs are registered, so `sel` is glitch-free at the mux.

---
 rtl/mux_sel_pkg.sv | 15 +
 rtl/rr_next_pick.sv | 29 ++
 rtl/mux4_rr_sequencer.sv | 109 ++++++++++
 tb/tb_mux4_rr_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mux_sel_pkg.sv
// Shared definitions for the 4:1 mux select sequencer.
// Provides the select width, channel count and the sequencer state encoding
// (IDLE = 1'b0, DWELL = 1'b1).
package mux_sel_pkg;

  localparam int SEL_W = 2;
  localparam int NCH   = 4;

  // ST_ prefix keeps the state names distinct from the DWELL parameter of the top.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DWELL = 1'b1
  } state_t;

endpackage

// File: rtl/rr_next_pick.sv
// Combinational round-robin picker: first requesting channel after sel, circularly.
// Ports: sel = current channel, req = request mask,
//        next = chosen channel, found = any request present.
module rr_next_pick
  import mux_sel_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  logic [NCH-1:0]   req,
  output logic [SEL_W-1:0] next,
  output logic             found
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    next  = sel;
    found = |req;
    idx   = sel;
    // Walk from the farthest offset (sel itself) down to sel+1 so the
    // nearest requester after sel overwrites any farther one.
    for (int off = NCH; off >= 1; off--) begin
      idx = sel + SEL_W'(off);
      if (req[idx]) begin
        next = idx;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_sequencer.sv
// Round-robin select sequencer for a 4:1 mux; holds each grant for DWELL cycles.
// Ports: clk/rst (sync, active-high), en, req[3:0] in;
//        registered sel[1:0], one-hot grant[3:0], valid, wrap pulse out.
module mux4_rr_sequencer
  import mux_sel_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NCH-1:0]   req,
  output logic [SEL_W-1:0] sel,
  output logic [NCH-1:0]   grant,
  output logic             valid,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_d;
  logic [NCH-1:0]   grant_d;
  logic             valid_d;
  logic             wrap_d;
  logic             advance;

  logic [SEL_W-1:0] pick;
  logic             found;

  rr_next_pick u_pick (
    .sel   (sel),
    .req   (req),
    .next  (pick),
    .found (found)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel;
    valid_d = valid;
    wrap_d  = 1'b0;
    advance = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en && found) begin
          advance = 1'b1;
        end
      end
      ST_DWELL: begin
        if (!en) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else if (cnt_q == '0) begin
          // Expiry (or an abort registered last cycle): one advance only.
          if (found) begin
            advance = 1'b1;
          end else begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end
        end else if (!req[sel]) begin
          // Abort: collapse the dwell so the next cycle behaves as expiry.
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase

    if (advance) begin
      state_d = ST_DWELL;
      sel_d   = pick;
      cnt_d   = CNT_LOAD;
      valid_d = 1'b1;
      // Same or lower index than the previous grant means the rotation wrapped.
      wrap_d  = (pick <= sel);
    end

    grant_d = valid_d ? (NCH'(1) << sel_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel     <= '1;
      grant   <= '0;
      valid   <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel     <= sel_d;
      grant   <= grant_d;
      valid   <= valid_d;
      wrap    <= wrap_d;
    end
  end

endmodule

// File: tb/tb_mux4_rr_sequencer.sv
// Testbench for mux4_rr_sequencer: two instances (DWELL=4 and DWELL=1) share stimulus.
// Directed phases follow the sequencer's rules, then randomized traffic; every
// cycle both instances are compared against a grant-level reference model.
module tb_mux4_rr_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] req;

  logic [1:0] sel4, sel1;
  logic [3:0] grant4, grant1;
  logic       valid4, valid1;
  logic       wrap4, wrap1;

  int checks   = 0;
  int failures = 0;

  // Reference model state per instance: granted channel, grant active,
  // cycles this grant has been held, wrap flag for the current cycle.
  int m_sel  [2];
  bit m_vld  [2];
  int m_held [2];
  bit m_wrap [2];
  int dwell_of [2] = '{4, 1};

  always #5 clk = ~clk;

  mux4_rr_sequencer #(.DWELL(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .sel(sel4), .grant(grant4), .valid(valid4), .wrap(wrap4)
  );

  mux4_rr_sequencer #(.DWELL(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .sel(sel1), .grant(grant1), .valid(valid1), .wrap(wrap1)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // First requester strictly after cur going round; cur itself only as last resort.
  function automatic int rr_pick(input int cur, input logic [3:0] r);
    for (int off = 1; off <= 4; off++) begin
      if (r[(cur + off) % 4]) return (cur + off) % 4;
    end
    return cur;
  endfunction

  task automatic model_grant(input int i);
    int nxt;
    nxt       = rr_pick(m_sel[i], req);
    m_wrap[i] = (nxt <= m_sel[i]);
    m_sel[i]  = nxt;
    m_vld[i]  = 1'b1;
    m_held[i] = 1;
  endtask

  task automatic model_step(input int i);
    m_wrap[i] = 1'b0;
    if (rst) begin
      m_sel[i]  = 3;
      m_vld[i]  = 1'b0;
      m_held[i] = 0;
    end else if (!m_vld[i]) begin
      if (en && req != 4'h0) model_grant(i);
    end else if (!en) begin
      m_vld[i] = 1'b0;
    end else if (m_held[i] >= dwell_of[i]) begin
      if (req != 4'h0) model_grant(i);
      else m_vld[i] = 1'b0;
    end else if (!req[m_sel[i]]) begin
      // Dropped request: the grant ends after one more cycle.
      m_held[i] = dwell_of[i];
    end else begin
      m_held[i]++;
    end
  endtask

  task automatic compare_all(input string ph);
    check_eq({ph, ":sel4"},   sel4,   m_sel[0]);
    check_eq({ph, ":valid4"}, valid4, m_vld[0]);
    check_eq({ph, ":grant4"}, grant4, m_vld[0] ? (1 << m_sel[0]) : 0);
    check_eq({ph, ":wrap4"},  wrap4,  m_wrap[0]);
    check_eq({ph, ":sel1"},   sel1,   m_sel[1]);
    check_eq({ph, ":valid1"}, valid1, m_vld[1]);
    check_eq({ph, ":grant1"}, grant1, m_vld[1] ? (1 << m_sel[1]) : 0);
    check_eq({ph, ":wrap1"},  wrap1,  m_wrap[1]);
  endtask

  // Drive inputs away from the edge, let one rising edge pass, then compare.
  task automatic cyc(input string ph, input bit r, input bit e, input logic [3:0] q);
    @(negedge clk);
    rst = r;
    en  = e;
    req = q;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all(ph);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    req = 4'hF;
    for (int i = 0; i < 2; i++) begin
      m_sel[i] = 3; m_vld[i] = 0; m_held[i] = 0; m_wrap[i] = 0;
    end

    // Reset held two cycles with traffic present.
    for (int k = 0; k < 2; k++) cyc("reset", 1'b1, 1'b1, 4'hF);
    check_eq("reset:sel_const", sel4, 3);
    check_eq("reset:valid_const", valid4, 0);

    // Full rotation: first grant lands on channel 0 with a wrap.
    cyc("rot", 1'b0, 1'b1, 4'hF);
    check_eq("rot:first_sel", sel4, 0);
    check_eq("rot:first_wrap", wrap4, 1);
    for (int k = 0; k < 19; k++) cyc("rot", 1'b0, 1'b1, 4'hF);

    // Sparse masks.
    for (int k = 0; k < 12; k++) cyc("sparse_a", 1'b0, 1'b1, 4'b1010);
    for (int k = 0; k < 12; k++) cyc("sparse_c", 1'b0, 1'b1, 4'b0100);

    // Abort: settle on channel 1 then drop its request mid-dwell.
    for (int k = 0; k < 6; k++) cyc("abort_pre", 1'b0, 1'b1, 4'b0010);
    cyc("abort", 1'b0, 1'b1, 4'b1100);
    cyc("abort", 1'b0, 1'b1, 4'b1100);
    check_eq("abort:sel4_new", sel4, 2);
    for (int k = 0; k < 4; k++) cyc("abort_post", 1'b0, 1'b1, 4'b0100);

    // Enable drop mid-dwell on channel 2, then resume with full mask.
    cyc("en_drop", 1'b0, 1'b0, 4'hF);
    check_eq("en_drop:sel4_hold", sel4, 2);
    cyc("en_resume", 1'b0, 1'b1, 4'hF);
    check_eq("en_resume:sel4", sel4, 3);
    for (int k = 0; k < 4; k++) cyc("en_resume", 1'b0, 1'b1, 4'hF);

    // Idle-out with no requests; sel must hold.
    for (int k = 0; k < 6; k++) cyc("idle", 1'b0, 1'b1, 4'h0);
    check_eq("idle:valid4", valid4, 0);

    // Randomized traffic with sticky masks, occasional enable drops and resets.
    begin
      logic [3:0] q;
      bit e, r;
      q = 4'hF;
      for (int k = 0; k < 3000; k++) begin
        if ($urandom_range(0, 3) == 0) q = 4'($urandom_range(0, 15));
        e = ($urandom_range(0, 15) != 0);
        r = ($urandom_range(0, 299) == 0);
        cyc("rand", r, e, q);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
